regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised register file for the datapath: DEPTH x DATA_W storage, one write port, two read ports (A, B).
//  Per-register valid bits and synchronous active-low clear.
//  Selectable write-to-read bypass; selectable registered (1-cycle) read.
//  Feeds the ALU A/B operand paths and the hazard logic (valid bits).
// PARAMETERS
//  DATA_W   16  word width in bits
//  ADDR_W   3   register index width; DEPTH = 2**ADDR_W
//  BYPASS   1   1: same-cycle write to the read index forwards data_in; 0: old contents returned
//  REG_OUT  0   0: combinational read (0-cycle); 1: read registered at posedge (1-cycle latency)
//  ZERO_R0  0   1: R0 reads as 0 and ignores writes; valid_x for R0 is always 1
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       synchronous active-low reset
//  write      in   1       write enable, sampled at posedge
//  writenum   in   ADDR_W  write index
//  data_in    in   DATA_W  write data
//  readnum_a  in   ADDR_W  read index, port A
//  readnum_b  in   ADDR_W  read index, port B
//  data_out_a out  DATA_W  read data, port A
//  data_out_b out  DATA_W  read data, port B
//  valid_a    out  1       register at readnum_a has been written since reset
//  valid_b    out  1       register at readnum_b has been written since reset
// BEHAVIOUR
//  - Reset: at posedge with reset_n=0:
//    - All registers are cleared to 0.
//    - All valid bits are cleared to 0.
//    - REG_OUT=1: data_out_x and valid_x registers are cleared to 0.
//    - write is ignored in that cycle; reset takes priority over a simultaneous write.
//  - Write: at posedge with reset_n=1 and write=1:
//    - reg[writenum] <= data_in and valid[writenum] <= 1.
//    - Exactly one register changes; valid bits are sticky until reset.
//  - Match condition: hit_x = write && (writenum == readnum_x) && reset_n.
//  - REG_OUT=0 (combinational read):
//    - data_out_x = (BYPASS && hit_x) ? data_in : reg[readnum_x].
//    - valid_x = (BYPASS && hit_x) | valid[readnum_x].
//    - Changes in readnum_x are visible with no clock edge.
//  - REG_OUT=1 (registered read): at each posedge with reset_n=1,
//    - data_out_x <= (BYPASS && hit_x) ? data_in : reg[readnum_x] (pre-write value); valid_x likewise.
//    - Result is visible 1 cycle after readnum_x is presented.
//  - BYPASS=0: a read hitting a same-cycle write returns the old value.
//    - REG_OUT=0: the new value appears after the edge.
//  - Ports A and B are fully independent; A==B is legal and gives identical outputs.
//  - ZERO_R0=1: writes to index 0 are dropped (no valid update); reads of index 0 return 0 with valid=1, including under bypass.
//  - X on readnum while REG_OUT=0: outputs X; no storage corruption.
//  - Reset mid-stream (REG_OUT=1): the first post-reset read output is that of the read presented at the first cycle with reset_n=1.
// STRUCTURE
//  - regfile_defs.vh: DATA_W/ADDR_W defaults, R0 index constant, reset value constant.
//  - Sub-module regfile_rd_port, instantiated twice (A, B):
//    - Inputs: storage vector, valid vector, readnum, write-side signals.
//    - Contains the bypass mux, ZERO_R0 override, and optional output register.
//  - Top level holds the storage array, the valid vector and the write decoder.
// TESTING (run all with BYPASS/REG_OUT in {0,1}x{0,1}; ZERO_R0=1 for test 6)
//  1. Reset: reset_n=0 for 1 edge, readnum_a=3 -> data_out_a=0, valid_a=0.
//  2. Write/read: write R1=7, then R5=16'hBEEF; readnum_a=1, readnum_b=5 -> 7 and 16'hBEEF, valid=1/1;
//     the REG_OUT=1 result arrives 1 cycle later.
//  3. Bypass: write R2=16'h1234 with readnum_a=2 in the same cycle, R2 previously 9:
//     - BYPASS=1 -> 16'h1234.
//     - BYPASS=0 -> 9 before the edge (REG_OUT=0) or in the sampled output (REG_OUT=1).
//  4. Reset priority: reset_n=0 with write=1, R4=16'hFFFF -> after the edge R4=0, valid=0.
//  5. Isolation: write all 8 registers with value 16'h0100+i, read every A/B pair -> no aliasing;
//     write=0 for 3 cycles -> no contents change.
//  6. ZERO_R0: write R0=5 -> read R0 = 0 with valid=1; R1 is unaffected.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned R0_IDX     = 0;
    localparam bit          RESET_BIT  = 1'b0;

endpackage : regfile_mp_pkg

// File: rtl/regfile_mp_rd_port.sv
// One read port: write bypass, R0 override and optional output register.
module regfile_mp_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          REG_OUT = 1'b0,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic [(2**ADDR_W)-1:0]                valid,
    input  logic [ADDR_W-1:0]                     readnum,
    input  logic                                  write,
    input  logic [ADDR_W-1:0]                     writenum,
    input  logic [DATA_W-1:0]                     data_in,
    output logic [DATA_W-1:0]                     data_out,
    output logic                                  valid_out
);

    logic              hit_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              rd_valid_c;

    assign hit_c = write && (writenum == readnum) && reset_n;

    // Storage read, then forwarding, then the hard-wired R0 override on top.
    always_comb begin
        rd_data_c  = regs[readnum];
        rd_valid_c = valid[readnum];
        if (BYPASS && hit_c) begin
            rd_data_c  = data_in;
            rd_valid_c = 1'b1;
        end
        if (ZERO_R0 && (readnum == ADDR_W'(R0_IDX))) begin
            rd_data_c  = '0;
            rd_valid_c = 1'b1;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [DATA_W-1:0] data_q;
            logic              valid_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    data_q  <= '0;
                    valid_q <= RESET_BIT;
                end else begin
                    data_q  <= rd_data_c;
                    valid_q <= rd_valid_c;
                end
            end

            assign data_out  = data_q;
            assign valid_out = valid_q;
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk;
            assign data_out   = rd_data_c;
            assign valid_out  = rd_valid_c;
        end
    endgenerate

endmodule : regfile_mp_rd_port

// File: rtl/regfile_mp.sv
// DEPTH x DATA_W register file: one write port, two read ports, per-register valid bits.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          REG_OUT = 1'b0,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_a,
    output logic              valid_b
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             valid;
    logic [DEPTH-1:0]             wr_sel_c;

    // Write decoder; R0 swallows writes when it is hard-wired to zero.
    always_comb begin
        wr_sel_c = '0;
        if (write && !(ZERO_R0 && (writenum == ADDR_W'(R0_IDX)))) begin
            wr_sel_c[writenum] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs  <= '0;
            valid <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_sel_c[i]) begin
                    regs[i]  <= data_in;
                    valid[i] <= 1'b1;
                end
            end
        end
    end

    regfile_mp_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .REG_OUT (REG_OUT),
        .ZERO_R0 (ZERO_R0)
    ) u_rd_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .regs      (regs),
        .valid     (valid),
        .readnum   (readnum_a),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .data_out  (data_out_a),
        .valid_out (valid_a)
    );

    regfile_mp_rd_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .REG_OUT (REG_OUT),
        .ZERO_R0 (ZERO_R0)
    ) u_rd_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .regs      (regs),
        .valid     (valid),
        .readnum   (readnum_b),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .data_out  (data_out_b),
        .valid_out (valid_b)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four BYPASS/REG_OUT builds plus a ZERO_R0 build on shared inputs.
module tb_regfile_mp;

    // Instance map: 0 B0/R0, 1 B1/R0, 2 B0/R1, 3 B1/R1, 4 B1/R0/ZERO_R0.
    logic        clk;
    logic        reset_n;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic [15:0] out_a [5];
    logic [15:0] out_b [5];
    logic        va    [5];
    logic        vb    [5];

    int checks   = 0;
    int failures = 0;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .REG_OUT(1'b0), .ZERO_R0(1'b0)) u_d0 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(out_a[0]), .data_out_b(out_b[0]),
        .valid_a(va[0]), .valid_b(vb[0]));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .REG_OUT(1'b0), .ZERO_R0(1'b0)) u_d1 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(out_a[1]), .data_out_b(out_b[1]),
        .valid_a(va[1]), .valid_b(vb[1]));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .REG_OUT(1'b1), .ZERO_R0(1'b0)) u_d2 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(out_a[2]), .data_out_b(out_b[2]),
        .valid_a(va[2]), .valid_b(vb[2]));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .REG_OUT(1'b1), .ZERO_R0(1'b0)) u_d3 (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(out_a[3]), .data_out_b(out_b[3]),
        .valid_a(va[3]), .valid_b(vb[3]));
    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .REG_OUT(1'b0), .ZERO_R0(1'b1)) u_dz (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum), .data_in(data_in),
        .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(out_a[4]), .data_out_b(out_b[4]),
        .valid_a(va[4]), .valid_b(vb[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] iso_exp(int k, int idx);
        if (k == 4 && idx == 0) return 16'h0000;
        return 16'h0100 + 16'(idx);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; write = 1'b0; writenum = 3'd0; data_in = 16'h0;
        readnum_a = 3'd3; readnum_b = 3'd0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_a[k] !== 16'h0000 || va[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_a inst%0d got %h/%b exp 0000/0", k, out_a[k], va[k]);
            end
            checks++;
            if (out_b[k] !== 16'h0000 || vb[k] !== (k == 4)) begin
                failures++;
                $display("FAIL reset_b_r0 inst%0d got %h/%b exp 0000/%b", k, out_b[k], vb[k], k == 4);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        write = 1'b1; writenum = 3'd1; data_in = 16'd7; readnum_a = 3'd0; readnum_b = 3'd0;
        tick();
        writenum = 3'd5; data_in = 16'hBEEF;
        tick();
        write = 1'b0; readnum_a = 3'd1; readnum_b = 3'd5;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2 || k == 3) begin
                checks++;
                if (out_a[k] !== 16'h0000 || va[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL wr_latency inst%0d got %h/%b exp 0000/0", k, out_a[k], va[k]);
                end
            end else begin
                checks++;
                if (out_a[k] !== 16'd7 || out_b[k] !== 16'hBEEF || va[k] !== 1'b1 || vb[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL wr_comb inst%0d got %h/%h %b%b exp 0007/beef 11", k, out_a[k], out_b[k], va[k], vb[k]);
                end
            end
        end
        tick();
        for (int k = 2; k < 4; k++) begin
            checks++;
            if (out_a[k] !== 16'd7 || out_b[k] !== 16'hBEEF || va[k] !== 1'b1 || vb[k] !== 1'b1) begin
                failures++;
                $display("FAIL wr_reg inst%0d got %h/%h %b%b exp 0007/beef 11", k, out_a[k], out_b[k], va[k], vb[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_d;
        logic        exp_v;
        write = 1'b1; writenum = 3'd2; data_in = 16'd9; readnum_a = 3'd0; readnum_b = 3'd0;
        tick();
        data_in = 16'h1234; readnum_a = 3'd2; readnum_b = 3'd2;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2 || k == 3) continue;
            exp_d = (k == 0) ? 16'd9 : 16'h1234;
            checks++;
            if (out_a[k] !== exp_d || out_b[k] !== exp_d) begin
                failures++;
                $display("FAIL bypass_pre inst%0d got %h/%h exp %h", k, out_a[k], out_b[k], exp_d);
            end
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_d = (k == 2) ? 16'd9 : 16'h1234;
            checks++;
            if (out_a[k] !== exp_d || out_b[k] !== exp_d) begin
                failures++;
                $display("FAIL bypass_post inst%0d got %h/%h exp %h", k, out_a[k], out_b[k], exp_d);
            end
        end
        // Forwarded valid on a never-written register.
        writenum = 3'd6; data_in = 16'h0066; readnum_a = 3'd6; readnum_b = 3'd3;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2 || k == 3) continue;
            exp_v = (k != 0);
            exp_d = (k == 0) ? 16'h0000 : 16'h0066;
            checks++;
            if (out_a[k] !== exp_d || va[k] !== exp_v || vb[k] !== 1'b0) begin
                failures++;
                $display("FAIL bypass_valid inst%0d got %h %b%b exp %h %b0", k, out_a[k], va[k], vb[k], exp_d, exp_v);
            end
        end
        tick();
        for (int k = 2; k < 4; k++) begin
            exp_v = (k == 3);
            exp_d = (k == 3) ? 16'h0066 : 16'h0000;
            checks++;
            if (out_a[k] !== exp_d || va[k] !== exp_v || vb[k] !== 1'b0) begin
                failures++;
                $display("FAIL bypass_valid_reg inst%0d got %h %b%b exp %h %b0", k, out_a[k], va[k], vb[k], exp_d, exp_v);
            end
        end
        write = 1'b0;
    endtask

    task automatic test_reset_priority();
        logic [15:0] exp_d;
        write = 1'b1; writenum = 3'd4; data_in = 16'hFFFF; readnum_a = 3'd0; readnum_b = 3'd0;
        tick();
        reset_n = 1'b0; readnum_a = 3'd4; readnum_b = 3'd4;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_a[k] !== 16'hFFFF || va[k] !== 1'b1) begin
                failures++;
                $display("FAIL rst_nobypass inst%0d got %h/%b exp ffff/1", k, out_a[k], va[k]);
            end
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_a[k] !== 16'h0000 || va[k] !== 1'b0) begin
                failures++;
                $display("FAIL rst_priority inst%0d got %h/%b exp 0000/0", k, out_a[k], va[k]);
            end
        end
        // First cycle out of reset also carries a write to the read index.
        reset_n = 1'b1; data_in = 16'h00AA;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_d = (k == 1) ? 16'h00AA : 16'h0000;
            checks++;
            if (out_a[k] !== exp_d || va[k] !== (k == 1)) begin
                failures++;
                $display("FAIL rst_first_comb inst%0d got %h/%b exp %h/%b", k, out_a[k], va[k], exp_d, k == 1);
            end
        end
        tick();
        write = 1'b0;
        for (int k = 2; k < 4; k++) begin
            exp_d = (k == 3) ? 16'h00AA : 16'h0000;
            checks++;
            if (out_a[k] !== exp_d || va[k] !== (k == 3)) begin
                failures++;
                $display("FAIL rst_first_reg inst%0d got %h/%b exp %h/%b", k, out_a[k], va[k], exp_d, k == 3);
            end
        end
    endtask

    task automatic test_isolation();
        for (int i = 0; i < 8; i++) begin
            write = 1'b1; writenum = 3'(i); data_in = 16'h0100 + 16'(i);
            tick();
        end
        write = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                readnum_a = 3'(a); readnum_b = 3'(b);
                tick();
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (out_a[k] !== iso_exp(k, a) || out_b[k] !== iso_exp(k, b) || va[k] !== 1'b1 || vb[k] !== 1'b1) begin
                        failures++;
                        $display("FAIL iso inst%0d a=%0d b=%0d got %h/%h %b%b exp %h/%h 11",
                                 k, a, b, out_a[k], out_b[k], va[k], vb[k], iso_exp(k, a), iso_exp(k, b));
                    end
                end
            end
        end
        writenum = 3'd3; data_in = 16'hDEAD;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            readnum_a = 3'(i); readnum_b = 3'(7 - i);
            tick();
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (out_a[k] !== iso_exp(k, i) || out_b[k] !== iso_exp(k, 7 - i)) begin
                    failures++;
                    $display("FAIL hold inst%0d i=%0d got %h/%h exp %h/%h",
                             k, i, out_a[k], out_b[k], iso_exp(k, i), iso_exp(k, 7 - i));
                end
            end
        end
    endtask

    task automatic test_zero_r0();
        write = 1'b1; writenum = 3'd0; data_in = 16'd5; readnum_a = 3'd0; readnum_b = 3'd1;
        #1;
        checks++;
        if (out_a[4] !== 16'h0000 || va[4] !== 1'b1 || out_b[4] !== 16'h0101 || vb[4] !== 1'b1) begin
            failures++;
            $display("FAIL zr0_bypass got %h/%h %b%b exp 0000/0101 11", out_a[4], out_b[4], va[4], vb[4]);
        end
        checks++;
        if (out_a[1] !== 16'd5) begin
            failures++;
            $display("FAIL zr0_ref_bypass got %h exp 0005", out_a[1]);
        end
        tick();
        write = 1'b0;
        #1;
        checks++;
        if (out_a[4] !== 16'h0000 || va[4] !== 1'b1 || out_b[4] !== 16'h0101 || vb[4] !== 1'b1) begin
            failures++;
            $display("FAIL zr0_after got %h/%h %b%b exp 0000/0101 11", out_a[4], out_b[4], va[4], vb[4]);
        end
        checks++;
        if (out_a[0] !== 16'd5) begin
            failures++;
            $display("FAIL zr0_ref_store got %h exp 0005", out_a[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
        readnum_a = '0; readnum_b = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_reset_priority();
        test_isolation();
        test_zero_r0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_mp
